// File: rtl/pmod_host.sv
// Host (initiator) side of the 2-bit Pmod link: serialises LEN, ADDR and write data
// or a waited read as LSB-first digits under a host-generated pck.
module pmod_host #(
  parameter int HALF_PERIOD = 16,
  parameter int MAX_WAIT    = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_len,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        pck,
  output logic        pwrite,
  output logic [1:0]  pwd,
  input  logic [1:0]  prd,
  input  logic        pwait
);

  // Handshake: a command transfers on a clk edge where cmd_valid && cmd_ready;
  // rsp_valid is a single-cycle completion pulse with rsp_rdata/rsp_error.

  localparam int TW = $clog2(HALF_PERIOD);
  localparam int WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, LEN, ADDR, WDATA, RDATA, RFIN, DONE} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [3:0]    cnt;
  logic [WW-1:0] wait_cnt;
  logic          write_q;
  logic [9:0]    len_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_sh;
  logic [1:0]    prd_meta, prd_s;
  logic          pwait_meta, pwait_s;
  logic          phase_end;
  logic          pulse_end;

  function automatic logic [1:0] digit(input logic [31:0] v, input logic [3:0] k);
    return v[{k, 1'b0} +: 2];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      prd_meta   <= 2'b00;
      prd_s      <= 2'b00;
      pwait_meta <= 1'b0;
      pwait_s    <= 1'b0;
    end else begin
      prd_meta   <= prd;
      prd_s      <= prd_meta;
      pwait_meta <= pwait;
      pwait_s    <= pwait_meta;
    end
  end

  // A pulse ends on the rising edge back to pck=1: that is the sample point
  // and the only moment pwd/pwrite are allowed to move.
  assign phase_end = (timer == TW'(HALF_PERIOD - 1));
  assign pulse_end = phase_end && !pck;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      wait_cnt  <= '0;
      write_q   <= 1'b0;
      len_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_sh  <= '0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
      pck       <= 1'b1;
      pwrite    <= 1'b0;
      pwd       <= 2'b00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            write_q   <= cmd_write;
            len_q     <= cmd_len;
            addr_q    <= cmd_addr;
            wdata_q   <= cmd_wdata;
            pwrite    <= cmd_write;
            pwd       <= cmd_len[1:0];
            cnt       <= '0;
            wait_cnt  <= '0;
            timer     <= '0;
            cmd_ready <= 1'b0;
            state     <= LEN;
          end
        end
        DONE: begin
          pwrite    <= 1'b0;
          pwd       <= 2'b00;
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          if (phase_end) begin
            timer <= '0;
            pck   <= ~pck;
          end else begin
            timer <= timer + 1'b1;
          end
          if (pulse_end) begin
            case (state)
              LEN: begin
                cnt <= cnt + 1'b1;
                if (cnt == 4'd4) begin
                  cnt   <= '0;
                  pwd   <= addr_q[1:0];
                  state <= ADDR;
                end else begin
                  pwd <= digit({22'd0, len_q}, cnt + 4'd1);
                end
              end
              ADDR: begin
                cnt <= cnt + 1'b1;
                if (cnt == 4'd15) begin
                  pwd   <= write_q ? wdata_q[1:0] : 2'b00;
                  state <= write_q ? WDATA : RDATA;
                end else begin
                  pwd <= digit(addr_q, cnt + 4'd1);
                end
              end
              WDATA: begin
                cnt <= cnt + 1'b1;
                if (cnt == 4'd15) begin
                  pwd       <= 2'b00;
                  rsp_error <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= DONE;
                end else begin
                  pwd <= digit(wdata_q, cnt + 4'd1);
                end
              end
              RDATA: begin
                if (pwait_s) begin
                  // Timeout leaves rsp_rdata holding the last good read.
                  if (wait_cnt == WW'(MAX_WAIT - 1)) begin
                    rsp_error <= 1'b1;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                  end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                  end
                end else begin
                  rdata_sh[{cnt, 1'b0} +: 2] <= prd_s;
                  cnt <= cnt + 1'b1;
                  if (cnt == 4'd15) state <= RFIN;
                end
              end
              RFIN: begin
                rsp_rdata <= rdata_sh;
                rsp_error <= 1'b0;
                rsp_valid <= 1'b1;
                state     <= DONE;
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule
